sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 105 ++++++++++
 tb/tb_sync_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, handshake pulses and occupancy flags.
// Define SYNC_FIFO_SVA_EN to compile the embedded assertions and cover properties.
module sync_fifo #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  almostfull,
    output logic                  empty,
    output logic                  almostempty
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt      = CntW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] AlmostFullCnt = CntW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] OneCnt        = CntW'(1);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic [FIFO_WIDTH-1:0] data_out_q;
    logic                  wr_ack_q, overflow_q, underflow_q;
    logic                  wr_accept, rd_accept;

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_accept = rd_en && (count_q != '0);
        wr_accept = wr_en && ((count_q != DepthCnt) || rd_accept);
        count_d   = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + OneCnt;
            2'b01:   count_d = count_q - OneCnt;
            default: count_d = count_q;
        endcase
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (rd_accept) begin
                rd_ptr_q   <= rd_ptr_q + PtrW'(1);
                data_out_q <= mem[rd_ptr_q];
            end
            count_q     <= count_d;
            wr_ack_q    <= wr_accept;
            overflow_q  <= wr_en && !wr_accept;
            underflow_q <= rd_en && (count_q == '0);
        end
    end

    assign data_out    = data_out_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign full        = (count_q == DepthCnt);
    assign almostfull  = (count_q == AlmostFullCnt);
    assign empty       = (count_q == '0);
    assign almostempty = (count_q == OneCnt);

`ifdef SYNC_FIFO_SVA_EN
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= DepthCnt);
    a_full_empty: assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));
    a_ack_ovf: assert property (@(posedge clk) disable iff (!rst_n) !(wr_ack && overflow));
    a_wr_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_accept && (wr_ptr_q == PtrW'(FIFO_DEPTH - 1))) |=> (wr_ptr_q == '0));
    a_rd_wrap: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_accept && (rd_ptr_q == PtrW'(FIFO_DEPTH - 1))) |=> (rd_ptr_q == '0));
    a_reset_vals: assert property (@(posedge clk) !rst_n |=>
        (wr_ptr_q == '0) && (rd_ptr_q == '0) && (count_q == '0) && (data_out_q == '0) &&
        !wr_ack_q && !overflow_q && !underflow_q);

    c_full: cover property (@(posedge clk) full);
    c_empty: cover property (@(posedge clk) empty);
    c_overflow: cover property (@(posedge clk) overflow);
    c_underflow: cover property (@(posedge clk) underflow);
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model predicts each cycle's
// outputs, and a monitor compares them against the DUT one step after every clock edge.
module tb_sync_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         wr_en = 1'b0;
    logic         rd_en = 1'b0;
    logic [W-1:0] data_out;
    logic         wr_ack, overflow, underflow;
    logic         full, almostfull, empty, almostempty;

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .wr_ack      (wr_ack),
        .overflow    (overflow),
        .underflow   (underflow),
        .full        (full),
        .almostfull  (almostfull),
        .empty       (empty),
        .almostempty (almostempty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         ack;
        logic         ovf;
        logic         unf;
        logic         full;
        logic         afull;
        logic         empty;
        logic         aempty;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] model_q[$];
    logic [W-1:0] model_dout = '0;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: every registered output and flag is meaningful each cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("data_out", 32'(data_out), 32'(e.dout));
            chk("wr_ack", 32'(wr_ack), 32'(e.ack));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("underflow", 32'(underflow), 32'(e.unf));
            chk("full", 32'(full), 32'(e.full));
            chk("almostfull", 32'(almostfull), 32'(e.afull));
            chk("empty", 32'(empty), 32'(e.empty));
            chk("almostempty", 32'(almostempty), 32'(e.aempty));
        end
    end

    // One clock of stimulus; the model decides acceptance from queue occupancy alone.
    task automatic step(input logic rst, input logic we, input logic re, input logic [W-1:0] din);
        exp_t e;
        int   sz;
        bit   rd_ok, wr_ok;
        @(negedge clk);
        rst_n   = rst;
        wr_en   = we;
        rd_en   = re;
        data_in = din;
        e = '0;
        if (!rst) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            sz    = model_q.size();
            rd_ok = re && (sz > 0);
            wr_ok = we && ((sz < D) || rd_ok);
            if (rd_ok) model_dout = model_q.pop_front();
            if (wr_ok) model_q.push_back(din);
            e.ack = wr_ok;
            e.ovf = we && !wr_ok;
            e.unf = re && (sz == 0);
        end
        sz       = model_q.size();
        e.dout   = model_dout;
        e.full   = (sz == D);
        e.afull  = (sz == D - 1);
        e.empty  = (sz == 0);
        e.aempty = (sz == 1);
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset dominates simultaneous requests.
        step(1'b0, 1'b1, 1'b1, 16'h5555);

        // Fill, overfill with 0xFFFF, drain.
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 16'(i));
        step(1'b1, 1'b1, 1'b0, 16'hFFFF);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 16'h0);

        // Reads while empty.
        step(1'b1, 1'b0, 1'b1, 16'h0);
        step(1'b1, 1'b0, 1'b1, 16'h0);

        // Simultaneous write/read while full.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h0100 + i));
        step(1'b1, 1'b1, 1'b1, 16'h00AA);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 16'h0);

        // Simultaneous write/read while empty.
        step(1'b1, 1'b1, 1'b1, 16'h1234);
        step(1'b1, 1'b0, 1'b1, 16'h0);

        // 20 pairs wrap both pointers.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'(16'h2000 + i));
            step(1'b1, 1'b0, 1'b1, 16'h0);
        end

        // Reset mid-stream at occupancy 5 discards contents.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h3000 + i));
        step(1'b0, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b0, 1'b1, 16'h0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 50), 16'($urandom_range(0, 65535)));
        end

        step(1'b1, 1'b0, 1'b0, 16'h0);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
